codec_cmd_queue: RTL and testbench
==================================

Name: codec_cmd_queue

Overview:
- Upstream command front-end for the CODEC register controller.
- Buffers register read/write requests from the software-facing register bank in a FIFO.
- Issues each request to the controller's codec_rd_en/codec_wr_en interface only when controller_busy is low.
- Tracks completion, captures read data and missed_ack, and returns exactly one in-order response per command over a valid/ready channel.

Parameters:
- DEPTH, 8, command FIFO entries (power of 2, at least 2).
- TIMEOUT_CYCLES, 1000000, maximum cycles from issue to completion before the command is aborted with an error.

Ports:
- clk  in  1  system clock (single domain, shared with the controller).
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  queue can accept a command (= not full).
- cmd_write  in  1  1 = register write, 0 = register read.
- cmd_addr  in  8  CODEC register address.
- cmd_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the command type.
- rsp_addr  out  8  echo of the command address.
- rsp_rdata  out  8  read data (0 for writes and errors).
- rsp_error  out  1  missed_ack, no read data, or timeout.
- codec_rd_en  out  1  one-cycle read strobe to the controller.
- codec_wr_en  out  1  one-cycle write strobe to the controller.
- codec_reg_addr  out  8  address to the controller.
- codec_data_in  out  8  write data to the controller.
- codec_data_out  in  8  read data from the controller.
- codec_data_out_valid  in  1  read data strobe.
- controller_busy  in  1  controller busy (held high during CODEC init).
- missed_ack  in  1  I2C NACK indication.
- queue_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- queue_empty  out  1  FIFO empty.

Behaviour:
- Reset (asynchronous assert, release on a clk edge):
  - FSM returns to IDLE; FIFO is emptied.
  - All outputs are 0 except cmd_ready=1 and queue_empty=1.
  - An in-flight command is discarded: no response, strobes drop immediately.
- FIFO push:
  - A command is pushed when cmd_valid && cmd_ready.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - A push while full is ignored (cmd_ready=0).
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Transition: if !queue_empty && !controller_busy, pop the head into the working registers → ISSUE.
  - Issue latency: a command pushed into an empty queue while the controller is idle is issued 2 cycles after the push edge.
- ISSUE:
  - Assert codec_rd_en or codec_wr_en for exactly 1 cycle, with codec_reg_addr/codec_data_in valid.
  - Clear the error flag and the timeout counter → WAIT_BUSY.
- WAIT_BUSY:
  - controller_busy=1 → WAIT_DONE.
- WAIT_DONE:
  - Read data: on codec_data_out_valid, capture codec_data_out and set got_data.
  - missed_ack=1 in any cycle after ISSUE sets the error flag.
  - controller_busy=0 → RESP.
  - A read that ends without got_data sets the error flag.
  - If codec_data_out_valid coincides with busy falling, the data is captured.
- Timeout:
  - The counter increments in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: go to RESP with error=1 and rdata=0.
- RESP:
  - rsp_valid=1 with stable rsp_* until rsp_ready → IDLE.
  - rsp_valid may not drop without rsp_ready.
  - Back-to-back: the next issue is earliest 1 cycle after the handshake.
- Strobe rules:
  - codec_rd_en and codec_wr_en are never high together.
  - Each strobe is never high for more than 1 cycle per command.
- Outputs are registered; queue_level is exact every cycle.

Decomposition:
- Package codec_cmd_pkg:
  - state enum cmd_state_e.
  - packed struct codec_cmd_t {write, addr[7:0], wdata[7:0]} (17 b).
  - packed struct codec_rsp_t {write, addr, rdata, error}.
  - localparams for strobe and timeout widths.
- Sub-module codec_cmd_fifo:
  - Synchronous FIFO of codec_cmd_t, DEPTH entries.
  - Ports: push/pop/full/empty/level.
  - Same async active-low reset.

Test Plan:
- Single write: controller idle, push {write=1, addr=0x04, wdata=0x1A} → codec_wr_en pulses 1 cycle 2 cycles after push with addr 0x04 / data 0x1A; busy high 10 cycles then low → rsp {write=1, addr=0x04, rdata=0, error=0}.
- Read: push read addr 0x10; model returns codec_data_out=0x5C with valid during busy → rsp_rdata=0x5C, error=0.
- Init hold and full queue: controller_busy=1, push 8 commands → cmd_ready=0, queue_level=8, 9th push ignored; release busy → 8 strobes and 8 responses in order, addresses match.
- Error cases: missed_ack pulse during a write → rsp_error=1; read where busy falls with no valid → rsp_error=1, rdata=0.
- Timeout: TIMEOUT_CYCLES=100, controller never raises busy → response exactly 100 cycles after ISSUE with error=1; next command still issues normally.
- Back-pressure and reset: hold rsp_ready=0 for 20 cycles → rsp stable, no new strobe; assert reset mid-WAIT_DONE → outputs at reset values immediately, queue_level=0, no response after release.

Source files
------------

// File: rtl/codec_cmd_pkg.sv
// rtl/codec_cmd_pkg.sv - shared types and widths for the CODEC command queue
package codec_cmd_pkg;

    localparam int REG_W     = 8;   // CODEC register address / data width
    localparam int TMO_CNT_W = 32;  // timeout counter width (covers any practical TIMEOUT_CYCLES)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } cmd_state_e;

    typedef struct packed {
        logic             write;
        logic [REG_W-1:0] addr;
        logic [REG_W-1:0] wdata;
    } codec_cmd_t;

    typedef struct packed {
        logic             write;
        logic [REG_W-1:0] addr;
        logic [REG_W-1:0] rdata;
        logic             error;
    } codec_rsp_t;

endpackage

// File: rtl/codec_cmd_fifo.sv
// rtl/codec_cmd_fifo.sv - synchronous FIFO of codec_cmd_t entries
// Ports: push/push_data write side, pop/pop_data read side (head is visible
// combinationally while not empty), full/empty flags, exact occupancy level.
module codec_cmd_fifo
    import codec_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  codec_cmd_t               push_data,
    input  logic                     pop,
    output codec_cmd_t               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    codec_cmd_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/codec_cmd_queue.sv
// rtl/codec_cmd_queue.sv - buffered register command front-end for the CODEC controller
// Ports: cmd_* command push channel, rsp_* in-order response channel,
// codec_* strobe/data interface to the controller, controller_busy and
// missed_ack status from the controller, queue_level/queue_empty occupancy.
module codec_cmd_queue
    import codec_cmd_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [7:0]             cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [7:0]             rsp_addr,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_error,
    output logic                   codec_rd_en,
    output logic                   codec_wr_en,
    output logic [7:0]             codec_reg_addr,
    output logic [7:0]             codec_data_in,
    input  logic [7:0]             codec_data_out,
    input  logic                   codec_data_out_valid,
    input  logic                   controller_busy,
    input  logic                   missed_ack,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   queue_empty
);

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    cmd_state_e            state_q, state_d;
    codec_cmd_t            cur_q, cur_d;
    codec_cmd_t            head;
    codec_rsp_t            rsp_q, rsp_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [7:0]            addr_q, addr_d, wdata_q, wdata_d;
    logic                  err_q, err_d, got_q, got_d;
    logic [7:0]            data_q, data_d;
    logic [TMO_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  fifo_full, fifo_empty, pop;
    logic                  err_now, got_now, fail_now;
    logic [7:0]            data_now;

    codec_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (queue_level)
    );

    assign cmd_ready      = !fifo_full;
    assign queue_empty    = fifo_empty;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_q.write;
    assign rsp_addr       = rsp_q.addr;
    assign rsp_rdata      = rsp_q.rdata;
    assign rsp_error      = rsp_q.error;
    assign codec_rd_en    = rd_en_q;
    assign codec_wr_en    = wr_en_q;
    assign codec_reg_addr = addr_q;
    assign codec_data_in  = wdata_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        got_d       = got_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        // Status seen this cycle is folded in so a data strobe or NACK that
        // coincides with the finishing edge still counts.
        err_now     = err_q | missed_ack;
        got_now     = got_q | codec_data_out_valid;
        data_now    = codec_data_out_valid ? codec_data_out : data_q;
        fail_now    = err_now | (!cur_q.write && !got_now);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !controller_busy) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_en_d = !cur_q.write;
                wr_en_d = cur_q.write;
                addr_d  = cur_q.addr;
                wdata_d = cur_q.wdata;
                err_d   = 1'b0;
                got_d   = 1'b0;
                data_d  = '0;
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                err_d  = err_now;
                got_d  = got_now;
                data_d = data_now;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == TMO_LAST) begin
                    rsp_d       = '{write: cur_q.write, addr: cur_q.addr, rdata: 8'h00, error: 1'b1};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (state_q == ST_WAIT_DONE && !controller_busy) begin
                    rsp_d       = '{write: cur_q.write, addr: cur_q.addr,
                                    rdata: (cur_q.write || fail_now) ? 8'h00 : data_now,
                                    error: fail_now};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (state_q == ST_WAIT_BUSY && controller_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            got_q       <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            got_q       <= got_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_codec_cmd_queue.sv
// tb/tb_codec_cmd_queue.sv - directed self-checking bench for codec_cmd_queue
module tb_codec_cmd_queue;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_error;
    logic [7:0] rsp_addr, rsp_rdata;
    logic       codec_rd_en, codec_wr_en;
    logic [7:0] codec_reg_addr, codec_data_in;
    logic [7:0] codec_data_out = '0;
    logic       codec_data_out_valid = 1'b0, controller_busy = 1'b0, missed_ack = 1'b0;
    logic [3:0] queue_level;
    logic       queue_empty;

    int checks = 0;
    int errors = 0;

    codec_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_addr             (cmd_addr),
        .cmd_wdata            (cmd_wdata),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_write            (rsp_write),
        .rsp_addr             (rsp_addr),
        .rsp_rdata            (rsp_rdata),
        .rsp_error            (rsp_error),
        .codec_rd_en          (codec_rd_en),
        .codec_wr_en          (codec_wr_en),
        .codec_reg_addr       (codec_reg_addr),
        .codec_data_in        (codec_data_in),
        .codec_data_out       (codec_data_out),
        .codec_data_out_valid (codec_data_out_valid),
        .controller_busy      (controller_busy),
        .missed_ack           (missed_ack),
        .queue_level          (queue_level),
        .queue_empty          (queue_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (!(codec_rd_en || codec_wr_en) && n < 400) begin
            step;
            n++;
        end
        chk({tag, "_strobe_seen"}, 32'(codec_rd_en || codec_wr_en), 32'd1);
    endtask

    // Called on the negedge where the strobe is visible; plays the controller.
    task automatic serve(input int busy_n, input logic give, input logic [7:0] dv, input logic nack);
        controller_busy = 1'b1;
        codec_data_out  = dv;
        for (int i = 0; i < busy_n; i++) begin
            codec_data_out_valid = give && (i == 3);
            missed_ack           = nack && (i == 2);
            step;
            if (i == 0) chk("strobe_one_cycle", 32'(codec_rd_en | codec_wr_en), 32'd0);
        end
        codec_data_out_valid = 1'b0;
        missed_ack           = 1'b0;
        controller_busy      = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic w, input logic [7:0] a,
                           input logic [7:0] rd, input logic er);
        int n;
        n = 0;
        while (!rsp_valid && n < 400) begin
            step;
            n++;
        end
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_error}),
            32'({1'b1, w, a, rd, er}));
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic       stable, quiet;
        logic [7:0] idx;
        int         n;

        // Reset values
        repeat (3) step;
        chk("reset_outputs", 32'({cmd_ready, queue_empty, queue_level, rsp_valid, codec_rd_en,
                                  codec_wr_en, codec_reg_addr, codec_data_in}),
            32'({1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
        reset = 1'b1;
        step;

        // Single write with exact issue latency
        push(1'b1, 8'h04, 8'h1A);
        chk("w_level_after_push", 32'(queue_level), 32'd1);
        chk("w_no_strobe_1", 32'(codec_rd_en | codec_wr_en), 32'd0);
        step;
        chk("w_no_strobe_2", 32'(codec_rd_en | codec_wr_en), 32'd0);
        step;
        chk("w_strobe", 32'({codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in}),
            32'({1'b1, 1'b0, 8'h04, 8'h1A}));
        serve(10, 1'b0, 8'h00, 1'b0);
        get_rsp("write", 1'b1, 8'h04, 8'h00, 1'b0);

        // Read with data
        push(1'b0, 8'h10, 8'h00);
        wait_strobe("read");
        chk("read_strobe", 32'({codec_rd_en, codec_wr_en, codec_reg_addr}), 32'({1'b1, 1'b0, 8'h10}));
        serve(8, 1'b1, 8'h5C, 1'b0);
        get_rsp("read", 1'b0, 8'h10, 8'h5C, 1'b0);

        // Init hold, full queue, ninth push ignored
        controller_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            idx = 8'(i);
            push(1'b1, 8'h20 + idx, idx);
        end
        chk("full_level", 32'({queue_level, cmd_ready}), 32'({4'd8, 1'b0}));
        step;
        chk("held_no_strobe", 32'(codec_rd_en | codec_wr_en), 32'd0);
        controller_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = 8'(i);
            wait_strobe("fifo");
            if (i == 0) chk("fifo_level_after_pop", 32'(queue_level), 32'd7);
            chk("fifo_strobe", 32'({codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_in}),
                32'({1'b0, 1'b1, 8'h20 + idx, idx}));
            serve(5, 1'b0, 8'h00, 1'b0);
            get_rsp("fifo", 1'b1, 8'h20 + idx, 8'h00, 1'b0);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            if (codec_rd_en || codec_wr_en || rsp_valid) quiet = 1'b0;
        end
        chk("fifo_no_ninth", 32'({quiet, queue_empty}), 32'({1'b1, 1'b1}));

        // Errors: NACK on write, read without data, data coinciding with busy fall
        push(1'b1, 8'h40, 8'hAA);
        wait_strobe("nack");
        serve(6, 1'b0, 8'h00, 1'b1);
        get_rsp("nack", 1'b1, 8'h40, 8'h00, 1'b1);
        push(1'b0, 8'h41, 8'h00);
        wait_strobe("nodata");
        serve(6, 1'b0, 8'hEE, 1'b0);
        get_rsp("nodata", 1'b0, 8'h41, 8'h00, 1'b1);
        push(1'b0, 8'h42, 8'h00);
        wait_strobe("lastdata");
        controller_busy = 1'b1;
        repeat (4) step;
        controller_busy      = 1'b0;
        codec_data_out_valid = 1'b1;
        codec_data_out       = 8'h9E;
        step;
        codec_data_out_valid = 1'b0;
        get_rsp("lastdata", 1'b0, 8'h42, 8'h9E, 1'b0);

        // Timeout: busy never rises
        push(1'b1, 8'h33, 8'h01);
        wait_strobe("tmo");
        n = 0;
        while (!rsp_valid && n < 300) begin
            step;
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TMO));
        get_rsp("tmo", 1'b1, 8'h33, 8'h00, 1'b1);
        push(1'b1, 8'h34, 8'h02);
        wait_strobe("after_tmo");
        chk("after_tmo_addr", 32'(codec_reg_addr), 32'h34);
        serve(5, 1'b0, 8'h00, 1'b0);
        get_rsp("after_tmo", 1'b1, 8'h34, 8'h00, 1'b0);

        // Push and pop in the same cycle, then response back-pressure
        push(1'b0, 8'h50, 8'h00);
        push(1'b1, 8'h51, 8'h11);
        chk("pushpop_level", 32'(queue_level), 32'd1);
        wait_strobe("bp");
        serve(6, 1'b1, 8'h77, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            step;
            n++;
        end
        stable = 1'b1;
        quiet  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_error} !== {1'b1, 1'b0, 8'h50, 8'h77, 1'b0})
                stable = 1'b0;
            if (codec_rd_en || codec_wr_en) quiet = 1'b0;
            step;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_no_strobe", 32'(quiet), 32'd1);
        get_rsp("bp", 1'b0, 8'h50, 8'h77, 1'b0);
        wait_strobe("bp_next");
        chk("bp_next_strobe", 32'({codec_wr_en, codec_reg_addr, codec_data_in}), 32'({1'b1, 8'h51, 8'h11}));
        serve(5, 1'b0, 8'h00, 1'b0);
        get_rsp("bp_next", 1'b1, 8'h51, 8'h00, 1'b0);

        // Reset in the middle of WAIT_DONE with one more command queued
        push(1'b1, 8'h60, 8'h05);
        push(1'b1, 8'h61, 8'h06);
        wait_strobe("rst");
        controller_busy = 1'b1;
        repeat (3) step;
        #2 reset = 1'b0;
        #1;
        chk("rst_async", 32'({cmd_ready, queue_empty, queue_level, rsp_valid, codec_rd_en,
                              codec_wr_en, codec_reg_addr, codec_data_in}),
            32'({1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
        step;
        reset = 1'b1;
        controller_busy = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step;
            if (rsp_valid || codec_rd_en || codec_wr_en) quiet = 1'b0;
        end
        chk("rst_no_response", 32'({quiet, queue_empty}), 32'({1'b1, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
